regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the 8x16 single-port register file.
- Depth and width are configurable.
- Provides two independent registered read ports and one write port.
- Adds an async-cleared storage array and a per-register pending scoreboard, so the datapath controller can stall on in-flight results.
- Sits between the instruction decoder/controller and the ALU operand latches of the datapath.

Parameters:
DATA_W, 16, width of each register and of all data ports
ADDR_W, 3, register index width; NREGS = 2**ADDR_W registers

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
write  input  1  write strobe; stores data_in into register writenum at posedge clk
writenum  input  ADDR_W  write register index
data_in  input  DATA_W  write data
rd_en_a  input  1  read request, port A
readnum_a  input  ADDR_W  read index, port A
data_out_a  output  DATA_W  registered read data, port A
valid_a  output  1  data_out_a updated by read issued on previous cycle
rd_en_b  input  1  read request, port B
readnum_b  input  ADDR_W  read index, port B
data_out_b  output  DATA_W  registered read data, port B
valid_b  output  1  data_out_b updated by read issued on previous cycle
reserve  input  1  mark register reserve_num pending (result in flight)
reserve_num  input  ADDR_W  register to reserve
busy_a  output  1  combinational: pending[readnum_a]
busy_b  output  1  combinational: pending[readnum_b]
sb_err  output  1  sticky: reserve issued to an already-pending register

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-operation):
  - all NREGS registers = 0; pending = all 0.
  - data_out_a/b = 0; valid_a/b = 0; sb_err = 0.
  - Deassertion is synchronous to clk (external synchroniser). The first edge after release operates normally.
- Write:
  - At posedge with write=1: R[writenum] <= data_in.
  - write=0: no register changes.
- Read (each port independent):
  - At posedge with rd_en_x=1: data_out_x <= R[readnum_x] and valid_x <= 1. Latency is 1 cycle.
  - rd_en_x=0: valid_x <= 0 and data_out_x holds its last value.
  - Both ports may read the same index in the same cycle; both return identical data.
- Read/write same cycle, same index: behaviour set by REGFILE_BYPASS_EN (below).
- Scoreboard (pending[NREGS]):
  - write=1 clears pending[writenum] at posedge.
  - reserve=1 sets pending[reserve_num] at posedge.
  - reserve and write to the same index in the same cycle: reserve wins, so the bit is 1 (a new producer supersedes).
  - reserve to an index whose bit is already 1: bit stays 1 and sb_err <= 1. sb_err stays 1 until reset.
  - write to a non-pending register is legal; the bit stays 0.
  - busy_a/busy_b reflect the current pending bits combinationally, before the edge. A same-cycle write does not clear busy until the next cycle.
- Index widths are exact (0..NREGS-1); no out-of-range case exists. No X is ever driven on any output after reset.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read at posedge with rd_en_x=1, write=1 and readnum_x==writenum captures data_in (write-first forwarding) on that port.
- Not defined: that read captures the pre-write value of R[writenum] (read-first). The new value is visible to reads issued on the following cycle.
- The storage update itself is identical in both builds.

Test Plan:
1. Reset, then rd_en_a=1 with readnum_a=5 -> next cycle data_out_a=0x0000, valid_a=1. Drop rd_en_a -> valid_a=0 and data_out_a holds 0x0000.
2. Write R2=0xBEEF and R7=0x1234. Then in one cycle rd_en_a with readnum_a=2 and rd_en_b with readnum_b=7 -> next cycle data_out_a=0xBEEF, data_out_b=0x1234, both valid.
3. R3=0x00AA. Same cycle: write R3=0x5555 and rd_en_a with readnum_a=3 -> data_out_a=0x5555 when REGFILE_BYPASS_EN is defined, 0x00AA when it is not. Read R3 on the following cycle -> 0x5555 in both builds.
4. reserve R4 -> busy_a=1 for readnum_a=4 from the next cycle. Write R4=0x0F0F -> busy_a still 1 in that cycle, 0 in the next cycle.
5. Same cycle: reserve R1 and write R1=0x0001 -> pending[1]=1 (busy for readnum_b=1) and R1=0x0001. Then reserve R1 again -> sb_err=1 and it stays 1 through further traffic.
6. Load R6=0xFFFF, reserve R6, then assert rst_n=0 mid-cycle with no clock edge -> outputs clear immediately. After release: R6 reads 0x0000, busy for index 6 is 0, sb_err=0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with pending scoreboard.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on reads.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] readnum_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_num,
  output logic              busy_a,
  output logic              busy_b,
  output logic              sb_err
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              sb_err_q, sb_err_d;
  logic [DATA_W-1:0] data_out_a_q, data_out_a_d;
  logic [DATA_W-1:0] data_out_b_q, data_out_b_d;
  logic              valid_a_q, valid_a_d;
  logic              valid_b_q, valid_b_d;
  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = regs_q[readnum_a];
    rd_b = regs_q[readnum_b];
`ifdef REGFILE_BYPASS_EN
    if (write && (writenum == readnum_a)) rd_a = data_in;
    if (write && (writenum == readnum_b)) rd_b = data_in;
`endif
  end

  always_comb begin
    regs_d = regs_q;
    if (write) regs_d[writenum] = data_in;
  end

  // Reserve applied after write so a new producer supersedes.
  always_comb begin
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (write) pending_d[writenum] = 1'b0;
    if (reserve) begin
      if (pending_q[reserve_num]) sb_err_d = 1'b1;
      pending_d[reserve_num] = 1'b1;
    end
  end

  always_comb begin
    data_out_a_d = rd_en_a ? rd_a : data_out_a_q;
    data_out_b_d = rd_en_b ? rd_b : data_out_b_q;
    valid_a_d    = rd_en_a;
    valid_b_d    = rd_en_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '{default: '0};
      pending_q    <= '0;
      sb_err_q     <= 1'b0;
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      pending_q    <= pending_d;
      sb_err_q     <= sb_err_d;
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
      valid_a_q    <= valid_a_d;
      valid_b_q    <= valid_b_d;
    end
  end

  assign data_out_a = data_out_a_q;
  assign data_out_b = data_out_b_q;
  assign valid_a    = valid_a_q;
  assign valid_b    = valid_b_q;
  assign busy_a     = pending_q[readnum_a];
  assign busy_b     = pending_q[readnum_b];
  assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed and random checks of regfile_2r1w against an array model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        rd_en_a, rd_en_b;
  logic [2:0]  readnum_a, readnum_b;
  logic [15:0] data_out_a, data_out_b;
  logic        valid_a, valid_b;
  logic        reserve;
  logic [2:0]  reserve_num;
  logic        busy_a, busy_b, sb_err;

  int checks = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [15:0] mregs [8];
  bit          mpend [8];
  bit          merr;
  logic [15:0] mout_a, mout_b;
  bit          mval_a, mval_b;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .write(write), .writenum(writenum), .data_in(data_in),
    .rd_en_a(rd_en_a), .readnum_a(readnum_a),
    .data_out_a(data_out_a), .valid_a(valid_a),
    .rd_en_b(rd_en_b), .readnum_b(readnum_b),
    .data_out_b(data_out_b), .valid_b(valid_b),
    .reserve(reserve), .reserve_num(reserve_num),
    .busy_a(busy_a), .busy_b(busy_b), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
    merr = 0; mout_a = '0; mout_b = '0; mval_a = 0; mval_b = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk16({tag, ".dout_a"}, data_out_a, mout_a);
    chk1({tag, ".valid_a"}, valid_a, mval_a);
    chk16({tag, ".dout_b"}, data_out_b, mout_b);
    chk1({tag, ".valid_b"}, valid_b, mval_b);
    chk1({tag, ".sb_err"}, sb_err, merr);
  endtask

  // One clock: drive at negedge, check busy, edge, update model, check.
  task automatic cyc(input string tag,
                     input bit w, input logic [2:0] wn, input logic [15:0] d,
                     input bit ra, input logic [2:0] rna,
                     input bit rb, input logic [2:0] rnb,
                     input bit rs, input logic [2:0] rsn);
    logic [15:0] ea, eb;
    write = w; writenum = wn; data_in = d;
    rd_en_a = ra; readnum_a = rna;
    rd_en_b = rb; readnum_b = rnb;
    reserve = rs; reserve_num = rsn;
    #1;
    chk1({tag, ".busy_a"}, busy_a, mpend[rna]);
    chk1({tag, ".busy_b"}, busy_b, mpend[rnb]);
    ea = (BYP && w && wn == rna) ? d : mregs[rna];
    eb = (BYP && w && wn == rnb) ? d : mregs[rnb];
    if (ra) mout_a = ea;
    if (rb) mout_b = eb;
    mval_a = ra;
    mval_b = rb;
    if (rs && mpend[rsn]) merr = 1;
    if (w) begin
      mregs[wn] = d;
      mpend[wn] = 0;
    end
    if (rs) mpend[rsn] = 1;
    @(posedge clk);
    #1;
    chk_outs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    write = 0; writenum = 0; data_in = 0;
    rd_en_a = 0; readnum_a = 0; rd_en_b = 0; readnum_b = 0;
    reserve = 0; reserve_num = 0;
    model_reset();
    #1;
    chk_outs("reset");
    chk1("reset.busy_a", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // 1: read after reset, then drop enable
    cyc("t1.rd", 0, 0, 0, 1, 5, 0, 0, 0, 0);
    chk16("t1.zero", data_out_a, 16'h0000);
    cyc("t1.idle", 0, 0, 0, 0, 5, 0, 0, 0, 0);
    chk1("t1.vdrop", valid_a, 1'b0);

    // 2: two writes, dual read
    cyc("t2.w2", 1, 2, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    cyc("t2.w7", 1, 7, 16'h1234, 0, 0, 0, 0, 0, 0);
    cyc("t2.rd", 0, 0, 0, 1, 2, 1, 7, 0, 0);
    chk16("t2.a", data_out_a, 16'hBEEF);
    chk16("t2.b", data_out_b, 16'h1234);
    cyc("t2.same", 0, 0, 0, 1, 7, 1, 7, 0, 0);

    // 3: read/write collision
    cyc("t3.w3", 1, 3, 16'h00AA, 0, 0, 0, 0, 0, 0);
    cyc("t3.col", 1, 3, 16'h5555, 1, 3, 0, 0, 0, 0);
    chk16("t3.col_val", data_out_a, BYP ? 16'h5555 : 16'h00AA);
    cyc("t3.next", 0, 0, 0, 1, 3, 0, 0, 0, 0);
    chk16("t3.next_val", data_out_a, 16'h5555);

    // 4: reserve then write clears busy a cycle later
    cyc("t4.rsv", 0, 0, 0, 0, 4, 0, 0, 1, 4);
    chk1("t4.busy", busy_a, 1'b1);
    cyc("t4.wr", 1, 4, 16'h0F0F, 0, 4, 0, 0, 0, 0);
    cyc("t4.after", 0, 0, 0, 1, 4, 0, 0, 0, 0);

    // 5: reserve wins over write; double reserve is sticky error
    cyc("t5.both", 1, 1, 16'h0001, 0, 0, 0, 1, 1, 1);
    cyc("t5.chk", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk1("t5.busy_b", busy_b, 1'b1);
    chk16("t5.r1", data_out_b, 16'h0001);
    cyc("t5.dup", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk1("t5.err", sb_err, 1'b1);
    cyc("t5.wclr", 1, 1, 16'h0002, 1, 1, 0, 0, 0, 0);
    cyc("t5.sticky", 0, 0, 0, 1, 1, 1, 1, 0, 0);
    chk1("t5.err_sticky", sb_err, 1'b1);

    // 6: asynchronous reset mid-cycle
    cyc("t6.w6", 1, 6, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    cyc("t6.rsv", 0, 0, 0, 1, 6, 1, 6, 1, 6);
    rd_en_a = 0; rd_en_b = 0; reserve = 0; write = 0;
    readnum_a = 6; readnum_b = 6;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk_outs("t6.async");
    chk1("t6.busy_a", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1;
    cyc("t6.rd6", 0, 0, 0, 1, 6, 1, 6, 0, 0);
    chk16("t6.r6", data_out_a, 16'h0000);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rnd",
          1'($urandom), 3'($urandom), 16'($urandom),
          1'($urandom), 3'($urandom),
          1'($urandom), 3'($urandom),
          ($urandom_range(0, 3) == 0), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
